// File: rtl/bcd_display_mux_if.sv
// Digit inputs and display outputs of the two-digit BCD scan driver.
// The master side feeds U/D; the slave side is the display mux itself.
interface bcd_display_mux_if;
    logic [3:0] U;
    logic [3:0] D;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    modport master (
        output U,
        output D,
        input  seg,
        input  an,
        input  frame_tick
    );

    modport slave (
        input  U,
        input  D,
        output seg,
        output an,
        output frame_tick
    );
endinterface

// File: rtl/bcd_display_mux.sv
// Purpose: scan two BCD digits onto a multiplexed 7-segment display, with anti-ghost gaps.
// Latency: seg/an/frame_tick are registered and change on the same edge as the scan state.
// Backpressure: none; U/D are sampled only on entry to the units slot, once per frame.
module bcd_display_mux #(
    parameter int REFRESH_DIV   = 4,
    parameter int GAP_CYC       = 2,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bcd_display_mux_if.slave   bus
);

    typedef enum logic [2:0] {
        INIT,
        DIG_U,
        GAP_U,
        DIG_D,
        GAP_D
    } state_t;

    localparam int MAX_DWELL = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CW        = $clog2(MAX_DWELL + 1);

    localparam logic [CW-1:0] DIG_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
    localparam logic [6:0]    SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_OFF   = ACTIVE_LOW ? 2'b11 : 2'b00;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    shadow_u_q, shadow_u_d;
    logic [3:0]    shadow_d_q, shadow_d_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic [6:0]    seg_hi;
    logic [1:0]    an_hi;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        shadow_u_d = shadow_u_q;
        shadow_d_d = shadow_d_q;
        tick_d     = 1'b0;
        seg_hi     = 7'b0;
        an_hi      = 2'b00;

        // INIT leaves on its second cycle: the reset edge itself is the first.
        case (state_q)
            INIT:    if (cnt_q != '0)       state_d = DIG_U;
            DIG_U:   if (cnt_q == DIG_LAST) state_d = (GAP_CYC > 0) ? GAP_U : DIG_D;
            GAP_U:   if (cnt_q == GAP_LAST) state_d = DIG_D;
            DIG_D:   if (cnt_q == DIG_LAST) state_d = (GAP_CYC > 0) ? GAP_D : DIG_U;
            GAP_D:   if (cnt_q == GAP_LAST) state_d = DIG_U;
            default: state_d = INIT;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if ((state_d == DIG_U) && (state_q != DIG_U)) begin
            shadow_u_d = bus.U;
            shadow_d_d = bus.D;
            tick_d     = 1'b1;
        end

        // Outputs follow the next state so the first lit cycle shows the fresh digit.
        case (state_d)
            DIG_U: begin
                an_hi  = 2'b01;
                seg_hi = decode(shadow_u_d);
            end
            DIG_D: begin
                if (!(BLANK_LEADING && (shadow_d_d == 4'd0))) begin
                    an_hi  = 2'b10;
                    seg_hi = decode(shadow_d_d);
                end
            end
            default: begin
                an_hi  = 2'b00;
                seg_hi = 7'b0;
            end
        endcase

        seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            shadow_u_q <= 4'd0;
            shadow_d_q <= 4'd0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_u_q <= shadow_u_d;
            shadow_d_q <= shadow_d_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: four parameterisations share clk/rst/U/D; a frame-position
// reference model pushes expected outputs per edge, popped and compared after the edge.
module tb_bcd_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] u_drv = 4'd3;
    logic [3:0] d_drv = 4'd1;

    always #5 clk = ~clk;

    bcd_display_mux_if if0();
    bcd_display_mux_if if1();
    bcd_display_mux_if if2();
    bcd_display_mux_if if3();

    assign if0.U = u_drv; assign if0.D = d_drv;
    assign if1.U = u_drv; assign if1.D = d_drv;
    assign if2.U = u_drv; assign if2.D = d_drv;
    assign if3.U = u_drv; assign if3.D = d_drv;

    bcd_display_mux u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bcd_display_mux #(.BLANK_LEADING(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_display_mux #(.GAP_CYC(0))          u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    bcd_display_mux #(.ACTIVE_LOW(1'b0))    u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    wire [39:0] obs_all = {if3.frame_tick, if3.an, if3.seg,
                           if2.frame_tick, if2.an, if2.seg,
                           if1.frame_tick, if1.an, if1.seg,
                           if0.frame_tick, if0.an, if0.seg};

    int cfg_rd [4] = '{4, 4, 4, 4};
    int cfg_gc [4] = '{2, 2, 0, 2};
    int cfg_bl [4] = '{1, 0, 1, 1};
    int cfg_al [4] = '{1, 1, 1, 0};

    // Model mode: 0 = reset cycle, 1 = INIT, 2 = scanning at m_pos within the frame.
    int         m_mode [4];
    int         m_pos  [4];
    logic [3:0] m_su   [4];
    logic [3:0] m_sd   [4];

    logic [39:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int an2_both_off = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        return t[v];
    endfunction

    task automatic model_push();
        logic [39:0] e;
        logic [6:0]  seg_h;
        logic [1:0]  an_h;
        logic        tick;
        int          frame;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            tick  = 1'b0;
            frame = 2 * (cfg_rd[k] + cfg_gc[k]);
            if (rst) begin
                m_mode[k] = 0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else begin
                m_pos[k] = (m_mode[k] == 1) ? 0 : (m_pos[k] + 1) % frame;
                m_mode[k] = 2;
                if (m_pos[k] == 0) begin
                    m_su[k] = u_drv;
                    m_sd[k] = d_drv;
                    tick    = 1'b1;
                end
            end
            seg_h = 7'h00;
            an_h  = 2'b00;
            if (m_mode[k] == 2) begin
                if (m_pos[k] < cfg_rd[k]) begin
                    an_h  = 2'b01;
                    seg_h = ref_seg(m_su[k]);
                end else if (m_pos[k] >= cfg_rd[k] + cfg_gc[k] &&
                             m_pos[k] < 2 * cfg_rd[k] + cfg_gc[k] &&
                             !(cfg_bl[k] == 1 && m_sd[k] == 4'd0)) begin
                    an_h  = 2'b10;
                    seg_h = ref_seg(m_sd[k]);
                end
            end
            if (cfg_al[k] == 1) begin
                an_h  = ~an_h;
                seg_h = ~seg_h;
            end
            e[k*10 +: 10] = {tick, an_h, seg_h};
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        logic [39:0] e;
        model_push();
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cyc%0d_cfg%0d", cyc, k), 32'(obs_all[k*10 +: 10]), 32'(e[k*10 +: 10]));
        end
        if (if2.an == 2'b11) an2_both_off++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the main instance shows frame position pos; an expired bound is a failure.
    task automatic seek_pos(input int pos, input string tag);
        int n;
        n = 0;
        while (!(m_mode[0] == 2 && m_pos[0] == pos) && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_reached"}, 32'(m_pos[0] == pos && m_mode[0] == 2), 32'd1);
    endtask

    initial begin
        // Reset with U=3 D=1 held for three cycles.
        rst = 1'b1; u_drv = 4'd3; d_drv = 4'd1;
        run(3);
        chk("rst_an",   32'(if0.an),         32'h3);
        chk("rst_seg",  32'(if0.seg),        32'h7F);
        chk("rst_tick", 32'(if0.frame_tick), 32'h0);
        rst = 1'b0;
        run(1);
        chk("init_an",   32'(if0.an),         32'h3);
        chk("init_tick", 32'(if0.frame_tick), 32'h0);
        run(1);
        chk("first_tick", 32'(if0.frame_tick), 32'h1);
        chk("first_an",   32'(if0.an),         32'h2);
        chk("first_seg",  32'(if0.seg),        32'b0110000);

        // Steady U=7 D=2.
        u_drv = 4'd7; d_drv = 4'd2;
        run(26);
        seek_pos(0, "u7");
        chk("u7_seg", 32'(if0.seg), 32'b1111000);
        seek_pos(6, "d2");
        chk("d2_seg", 32'(if0.seg), 32'b0100100);

        // Leading-zero blanking of the tens digit.
        u_drv = 4'd5; d_drv = 4'd0;
        run(14);
        seek_pos(6, "d0");
        chk("d0_blank_an", 32'(if0.an), 32'h3);
        chk("d0_nb_seg",   32'(if1.seg), 32'b1000000);
        chk("d0_nb_an",    32'(if1.an),  32'h1);
        run(10);

        // U changed mid tens slot takes effect exactly on the next tick.
        u_drv = 4'd3; d_drv = 4'd1;
        run(12);
        seek_pos(6, "u3");
        u_drv = 4'd9;
        for (int i = 0; i < 20 && if0.frame_tick !== 1'b1; i++) step();
        chk("u9_tick", 32'(if0.frame_tick), 32'h1);
        chk("u9_seg",  32'(if0.seg),        32'b0010000);
        run(12);

        // Non-BCD digits show a dash; the no-gap instance never blanks both anodes.
        u_drv = 4'hC; d_drv = 4'hF;
        an2_both_off = 0;
        run(24);
        chk("dash_seg", 32'(if0.seg), 32'b0111111);
        chk("nogap_no_11", 32'(an2_both_off), 32'd0);

        // One-cycle reset in the second cycle of the tens slot.
        u_drv = 4'd4; d_drv = 4'd6;
        seek_pos(7, "midrst");
        rst = 1'b1; u_drv = 4'd8;
        run(1);
        chk("midrst_an",  32'(if0.an),  32'h3);
        chk("midrst_seg", 32'(if0.seg), 32'h7F);
        rst = 1'b0;
        run(1);
        chk("midrst_init_an", 32'(if0.an), 32'h3);
        run(1);
        chk("midrst_tick", 32'(if0.frame_tick), 32'h1);
        chk("midrst_seg8", 32'(if0.seg),        32'b0000000);
        run(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
